// File: rtl/dcache_nway.sv
// N-way set-associative write-back, write-allocate L1 data cache with true-LRU
// replacement, set/way halt flush and saturating hit/miss statistics.
module dcache_nway #(
  parameter int WAYS  = 4,
  parameter int SETS  = 8,
  parameter int WORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  // state    | meaning
  // IDLE     | serve hits, detect misses and halt
  // WB       | write back the dirty victim block
  // FETCH    | fill the victim frame from memory
  // FLUSH    | scan (set, way) for dirty frames
  // FLUSH_WB | write back the frame under the scan pointer
  // DONE     | flush complete, requests ignored
  localparam logic [2:0] IDLE = 3'd0, WB = 3'd1, FETCH = 3'd2,
                         FLUSH = 3'd3, FLUSH_WB = 3'd4, DONE = 3'd5;

  localparam int OB = $clog2(WORDS);
  localparam int IB = $clog2(SETS);
  localparam int TW = 30 - OB - IB;
  localparam int AW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int BW = (WORDS > 1) ? OB : 1;

  logic [2:0]    state;
  logic          valid [SETS][WAYS];
  logic          dirty [SETS][WAYS];
  logic [TW-1:0] tags  [SETS][WAYS];
  logic [31:0]   data  [SETS][WAYS][WORDS];
  logic [AW-1:0] age   [SETS][WAYS];

  logic [TW-1:0] m_tag;
  logic [IB-1:0] m_idx;
  logic [AW-1:0] vic;
  logic [BW-1:0] cnt;
  logic [IB-1:0] f_set;
  logic [AW-1:0] f_way;

  logic [BW-1:0] r_off;
  logic [IB-1:0] r_idx;
  logic [TW-1:0] r_tag;
  logic          req, hit, miss, any_inv, last, flush_last, lru_en;
  logic [AW-1:0] hway, vic_n, lru_way;
  logic [IB-1:0] lru_set;

  assign r_off = (WORDS > 1) ? dmemaddr[2 +: BW] : '0;
  assign r_idx = dmemaddr[2+OB +: IB];
  assign r_tag = dmemaddr[2+OB+IB +: TW];
  assign req   = dmemREN | dmemWEN;

  function automatic logic [31:0] mk_addr(input logic [TW-1:0] t, input logic [IB-1:0] i,
                                          input logic [BW-1:0] c);
    logic [31:0] a;
    a = '0;
    a[2+OB+IB +: TW] = t;
    a[2+OB +: IB] = i;
    if (WORDS > 1) a[2 +: BW] = c;
    return a;
  endfunction

  always_comb begin
    hit  = 1'b0;
    hway = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid[r_idx][w] && tags[r_idx][w] == r_tag) begin
        hit  = 1'b1;
        hway = AW'(w);
      end
  end

  // Lowest-index invalid way wins; otherwise the oldest way of the set.
  always_comb begin
    vic_n   = '0;
    any_inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid[r_idx][w]) begin
        vic_n   = AW'(w);
        any_inv = 1'b1;
      end
    if (!any_inv)
      for (int w = 0; w < WAYS; w++)
        if (age[r_idx][w] == AW'(WAYS - 1)) vic_n = AW'(w);
  end

  assign dhit       = (state == IDLE) && req && hit;
  assign miss       = (state == IDLE) && req && !hit;
  assign dmemload   = dhit ? data[r_idx][hway][r_off] : 32'd0;
  assign flushed    = (state == DONE);
  assign last       = (cnt == BW'(WORDS - 1));
  assign flush_last = (f_set == IB'(SETS - 1)) && (f_way == AW'(WAYS - 1));
  assign lru_en     = dhit || (state == FETCH && !dwait && last);
  assign lru_set    = dhit ? r_idx : m_idx;
  assign lru_way    = dhit ? hway : vic;

  always_comb begin
    dREN   = 1'b0;
    dWEN   = 1'b0;
    daddr  = 32'd0;
    dstore = 32'd0;
    case (state)
      WB: begin
        dWEN   = 1'b1;
        daddr  = mk_addr(tags[m_idx][vic], m_idx, cnt);
        dstore = data[m_idx][vic][cnt];
      end
      FETCH: begin
        dREN  = 1'b1;
        daddr = mk_addr(m_tag, m_idx, cnt);
      end
      FLUSH_WB: begin
        dWEN   = 1'b1;
        daddr  = mk_addr(tags[f_set][f_way], f_set, cnt);
        dstore = data[f_set][f_way][cnt];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      cnt        <= '0;
      m_tag      <= '0;
      m_idx      <= '0;
      vic        <= '0;
      f_set      <= '0;
      f_way      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          valid[s][w] <= 1'b0;
          dirty[s][w] <= 1'b0;
          age[s][w]   <= AW'(w);
        end
    end else begin
      if (lru_en)
        for (int w = 0; w < WAYS; w++)
          if (AW'(w) == lru_way) age[lru_set][w] <= '0;
          else if (age[lru_set][w] < age[lru_set][lru_way])
            age[lru_set][w] <= age[lru_set][w] + AW'(1);
      if (dhit && hit_count != '1) hit_count <= hit_count + 32'd1;
      if (miss && miss_count != '1) miss_count <= miss_count + 32'd1;
      case (state)
        IDLE: begin
          if (miss) begin
            m_tag <= r_tag;
            m_idx <= r_idx;
            vic   <= vic_n;
            cnt   <= '0;
            state <= (valid[r_idx][vic_n] && dirty[r_idx][vic_n]) ? WB : FETCH;
          end else begin
            if (dhit && dmemWEN) dirty[r_idx][hway] <= 1'b1;
            if (halt) begin
              f_set <= '0;
              f_way <= '0;
              state <= FLUSH;
            end
          end
        end
        WB: if (!dwait) begin
          cnt <= last ? '0 : cnt + BW'(1);
          if (last) state <= FETCH;
        end
        FETCH: if (!dwait) begin
          cnt <= last ? '0 : cnt + BW'(1);
          if (last) begin
            valid[m_idx][vic] <= 1'b1;
            dirty[m_idx][vic] <= 1'b0;
            state <= IDLE;
          end
        end
        FLUSH: begin
          if (valid[f_set][f_way] && dirty[f_set][f_way]) begin
            cnt   <= '0;
            state <= FLUSH_WB;
          end else if (flush_last) state <= DONE;
          else if (f_way == AW'(WAYS - 1)) begin
            f_way <= '0;
            f_set <= f_set + IB'(1);
          end else f_way <= f_way + AW'(1);
        end
        FLUSH_WB: if (!dwait) begin
          cnt <= last ? '0 : cnt + BW'(1);
          if (last) begin
            dirty[f_set][f_way] <= 1'b0;
            if (flush_last) state <= DONE;
            else begin
              state <= FLUSH;
              if (f_way == AW'(WAYS - 1)) begin
                f_way <= '0;
                f_set <= f_set + IB'(1);
              end else f_way <= f_way + AW'(1);
            end
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

  // Block payload and tags carry no reset; valid bits guard them.
  always_ff @(posedge CLK) begin
    if (dhit && dmemWEN) data[r_idx][hway][r_off] <= dmemstore;
    if (state == FETCH && !dwait) begin
      data[m_idx][vic][cnt] <= dload;
      if (last) tags[m_idx][vic] <= m_tag;
    end
  end
endmodule

// File: tb/tb_dcache_nway.sv
// Scoreboard bench for dcache_nway: expected memory transfers and read data are
// queued by the stimulus and popped by an independent negedge monitor.
module tb_dcache_nway;
  logic        CLK = 1'b0, nRST;
  logic        dmemREN, dmemWEN, halt, dhit, flushed, dREN, dWEN, dwait;
  logic [31:0] dmemaddr, dmemstore, dmemload, daddr, dstore, dload;
  logic [31:0] hit_count, miss_count;

  dcache_nway #(.WAYS(4), .SETS(8), .WORDS(2)) dut (
    .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .halt(halt), .dhit(dhit),
    .dmemload(dmemload), .flushed(flushed), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .hit_count(hit_count), .miss_count(miss_count));

  always #5 CLK = ~CLK;

  typedef struct {bit we; logic [31:0] addr; logic [31:0] data;} xfer_t;
  xfer_t       mem_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] mem [logic [31:0]];
  int vectors = 0, miscompares = 0;
  int wb_xfers = 0, stall_cnt = 0;
  bit stall_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bg(input logic [31:0] a);
    return 32'hC0DE_0000 | a;
  endfunction

  task automatic exp_rd(input logic [31:0] a);
    mem_q.push_back('{1'b0, a, 32'h0});
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    mem_q.push_back('{1'b1, a, d});
  endtask

  // Memory model: background pattern unless written back; optional 3-cycle stall per word.
  initial begin
    dwait = 1'b0;
    dload = 32'h0;
    forever begin
      @(posedge CLK);
      #2;
      if (stall_en && nRST && (dREN || dWEN)) begin
        if (stall_cnt < 3) begin dwait = 1'b1; stall_cnt++; end
        else begin dwait = 1'b0; stall_cnt = 0; end
      end else begin
        dwait = 1'b0;
        stall_cnt = 0;
      end
      dload = mem.exists(daddr) ? mem[daddr] : bg(daddr);
    end
  end

  initial begin
    logic        prev_wait;
    logic [31:0] prev_addr;
    xfer_t       e;
    prev_wait = 1'b0;
    prev_addr = 32'h0;
    forever begin
      @(negedge CLK);
      if (nRST === 1'b1) begin
        if (dREN || dWEN) check("mem_req_excl", 32'(dREN & dWEN), 32'h0);
        if (prev_wait && (dREN || dWEN)) check("daddr_hold", daddr, prev_addr);
        if ((dREN || dWEN) && !dwait) begin
          if (mem_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL mem_xfer: unexpected we=%0d addr %h", dWEN, daddr);
          end else begin
            e = mem_q.pop_front();
            check("mem_dir", 32'(dWEN), 32'(e.we));
            check("mem_addr", daddr, e.addr);
            if (e.we) check("mem_wdata", dstore, e.data);
          end
          if (dWEN) begin
            wb_xfers++;
            mem[daddr] = dstore;
          end
        end
        if (dhit && dmemREN && !dmemWEN) begin
          if (rd_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL rd_data: unexpected hit data %h", dmemload);
          end else check("rd_data", dmemload, rd_q.pop_front());
        end
        prev_wait = dwait && (dREN || dWEN);
        prev_addr = daddr;
      end else prev_wait = 1'b0;
    end
  end

  task automatic access(input bit we, input logic [31:0] a, input logic [31:0] d,
                        input int exp_lat, input string name);
    int lat;
    @(posedge CLK);
    #1;
    dmemWEN = we;
    dmemREN = !we;
    dmemaddr = a;
    dmemstore = d;
    lat = 0;
    forever begin
      @(negedge CLK);
      if (dhit || lat > 200) break;
      lat++;
    end
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    @(posedge CLK);
    #1;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp_d, input int exp_lat,
                    input string name);
    rd_q.push_back(exp_d);
    access(1'b0, a, 32'h0, exp_lat, name);
  endtask

  task automatic fill_exp(input logic [31:0] a);
    exp_rd(a);
    exp_rd(a + 32'h4);
  endtask

  task automatic do_reset;
    @(negedge CLK);
    #2;
    nRST = 1'b0;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    halt = 1'b0;
    stall_en = 1'b0;
    mem.delete();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    logic [31:0] fills [4];
    int n, hits;
    fills = '{32'h000, 32'h040, 32'h080, 32'h0C0};
    nRST = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0;
    dmemaddr = 32'h0; dmemstore = 32'h0;
    repeat (2) @(negedge CLK);
    check("rst_dhit", 32'(dhit), 32'h0);
    check("rst_dmemload", dmemload, 32'h0);
    check("rst_flushed", 32'(flushed), 32'h0);
    check("rst_dren", 32'(dREN), 32'h0);
    check("rst_dwen", 32'(dWEN), 32'h0);
    check("rst_daddr", daddr, 32'h0);
    check("rst_dstore", dstore, 32'h0);
    check("rst_hits", hit_count, 32'h0);
    check("rst_misses", miss_count, 32'h0);
    nRST = 1'b1;

    // Cold miss then same-cycle hit
    fill_exp(32'h100);
    rd(32'h100, bg(32'h100), 3, "cold_rd");
    rd(32'h100, bg(32'h100), 0, "rehit");
    check("t1_hits", hit_count, 32'd2);
    check("t1_misses", miss_count, 32'd1);

    // LRU eviction in set 0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      fill_exp(fills[i]);
      rd(fills[i], bg(fills[i]), 3, "fill_way");
    end
    fill_exp(32'h100);
    rd(32'h100, bg(32'h100), 3, "evict_w0");
    rd(32'h040, bg(32'h040), 0, "lru_rehit");
    fill_exp(32'h000);
    rd(32'h000, bg(32'h000), 3, "evicted_miss");
    rd(32'h0C0, bg(32'h0C0), 0, "w3_still_hit");

    // Dirty victim write-back
    do_reset();
    fill_exp(32'h000);
    access(1'b1, 32'h000, 32'hDEADBEEF, 3, "wr_miss");
    for (int i = 1; i < 4; i++) begin
      fill_exp(fills[i]);
      rd(fills[i], bg(fills[i]), 3, "fill_way");
    end
    exp_wr(32'h000, 32'hDEADBEEF);
    exp_wr(32'h004, bg(32'h004));
    fill_exp(32'h100);
    rd(32'h100, bg(32'h100), 5, "dirty_evict");
    fill_exp(32'h000);
    rd(32'h000, 32'hDEADBEEF, 3, "readback");
    check("t3_misses", miss_count, 32'd6);
    check("t3_hits", hit_count, 32'd6);

    // Halt flush of two dirty frames
    do_reset();
    fill_exp(32'h008);
    access(1'b1, 32'h008, 32'h11111111, 3, "wr_a");
    fill_exp(32'h1F8);
    access(1'b1, 32'h1F8, 32'h22222222, 3, "wr_b");
    exp_wr(32'h008, 32'h11111111);
    exp_wr(32'h00C, bg(32'h00C));
    exp_wr(32'h1F8, 32'h22222222);
    exp_wr(32'h1FC, bg(32'h1FC));
    wb_xfers = 0;
    @(posedge CLK);
    #1 halt = 1'b1;
    n = 0;
    while (!flushed && n < 300) begin
      @(negedge CLK);
      n++;
    end
    check("flushed", 32'(flushed), 32'h1);
    check("flush_wb_count", 32'(wb_xfers), 32'd4);
    repeat (5) @(negedge CLK);
    check("flushed_sticky", 32'(flushed), 32'h1);
    @(posedge CLK);
    #1;
    dmemREN = 1'b1;
    dmemaddr = 32'h008;
    hits = 0;
    repeat (4) begin
      @(negedge CLK);
      if (dhit) hits++;
    end
    check("done_no_hit", 32'(hits), 32'h0);
    check("done_hit_count", hit_count, 32'd2);
    dmemREN = 1'b0;

    // Stalled fill
    do_reset();
    stall_en = 1'b1;
    fill_exp(32'h100);
    rd(32'h100, bg(32'h100), 9, "stall_fill");
    stall_en = 1'b0;

    // Asynchronous reset during FETCH word 1
    do_reset();
    fill_exp(32'h100);
    @(posedge CLK);
    #1;
    dmemREN = 1'b1;
    dmemaddr = 32'h100;
    repeat (3) @(negedge CLK);
    check("fetch_w1_dren", 32'(dREN), 32'h1);
    check("fetch_w1_addr", daddr, 32'h104);
    #2 nRST = 1'b0;
    #1;
    check("arst_dren", 32'(dREN), 32'h0);
    check("arst_daddr", daddr, 32'h0);
    check("arst_misses", miss_count, 32'h0);
    dmemREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    fill_exp(32'h100);
    rd(32'h100, bg(32'h100), 3, "post_rst_miss");
    check("post_rst_misses", miss_count, 32'd1);

    repeat (3) @(negedge CLK);
    check("mem_q_empty", 32'(mem_q.size()), 32'h0);
    check("rd_q_empty", 32'(rd_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dcache_nway.md
# dcache_nway

Parametrised N-way set-associative, write-back, write-allocate L1 data cache. It sits between the datapath memory port and the memory controller's data channel. It generalises the two-way cache to configurable ways, sets and block size. Replacement is true-LRU via per-set age counters, the halt flush is a set/way scan, and hit/miss statistics are exposed.

## Interface
- WAYS, 4: associativity; power of two, 1–16.
- SETS, 8: number of sets; power of two, 2 or more.
- WORDS, 2: 32-bit words per block; power of two, 1–8.
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- dmemREN, dmemWEN  in  1 each  datapath read/write request.
- dmemaddr  in  32  byte address. Split from LSB: byte offset[1:0], blkoff log2(WORDS), idx log2(SETS), tag = remainder.
- dmemstore  in  32  write data.
- halt  in  1  request flush of dirty data.
- dhit  out  1  request satisfied this cycle.
- dmemload  out  32  read data, valid when dhit.
- flushed  out  1  flush complete; sticky.
- dREN, dWEN  out  1 each  memory read/write request.
- daddr  out  32  memory word address, low 2 bits always 00.
- dstore  out  32  memory write data.
- dload  in  32  memory read data.
- dwait  in  1  memory busy; a word transfer completes on a cycle with dwait=0.
- hit_count, miss_count  out  32 each  statistics, saturating.

## Operation
- Frame per (set, way): valid, dirty, tag, WORDS data words. On reset, all valid and dirty bits are 0.
- Hit: state IDLE, (dmemREN|dmemWEN), and some way in set idx is valid with a matching tag. At most one way may match.
- If dmemREN and dmemWEN are both high, the request is treated as a write.
- Read hit: dhit=1 and dmemload = data[blkoff] of the hitting way, same cycle.
- Write hit: dhit=1; data[blkoff] <= dmemstore and dirty <= 1 at the next edge.
- LRU: each set holds WAYS age counters of log2(WAYS) bits. Reset value of way w's age is w.
- On a hit or fill to way h: age[h] <= 0, and every way whose age is below the old age[h] increments by 1. The ages of a set therefore always form a permutation of 0..WAYS-1.
- Victim selection: the lowest-index invalid way; if all ways are valid, the way with age WAYS-1. The victim is latched on miss entry.
- FSM states: IDLE, WB, FETCH, FLUSH, FLUSH_WB, DONE.
- IDLE → WB on a miss with a valid, dirty victim. IDLE → FETCH on a miss with a clean or invalid victim.
- WB: dWEN=1; daddr = {victim tag, idx, word counter, 00}; dstore = victim word. The counter advances on dwait=0. After word WORDS-1 completes → FETCH.
- FETCH: dREN=1; daddr = {req tag, idx, counter, 00}. On dwait=0, dload is written into the victim frame. After the last word: tag written, valid=1, dirty=0, LRU updated → IDLE. The request then hits on the following cycle.
- IDLE with halt=1 and no miss pending → FLUSH. A miss already in progress completes first; halt is sampled again in IDLE.
- FLUSH scans the (set, way) pointer from (0,0), way-minor. A valid, dirty frame → FLUSH_WB, which writes back WORDS words as in WB, then clears dirty and returns to FLUSH at the next pointer. A clean or invalid frame advances the pointer one per cycle. After (SETS-1, WAYS-1) → DONE.
- DONE: flushed=1 until reset. dhit=0; requests are ignored.
- In FLUSH, FLUSH_WB and DONE, dhit=0, and no frame or LRU state changes other than clearing dirty.
- hit_count increments on each cycle with dhit=1. miss_count increments on each IDLE→WB or IDLE→FETCH transition. Both saturate at 0xFFFFFFFF.

## Timing
- Reset values: dhit=0, dmemload=0, flushed=0, dREN=0, dWEN=0, daddr=0, dstore=0, hit_count=0, miss_count=0, state=IDLE.
- Hit latency: 0 cycles, combinational from the request.
- Miss latency with dwait=0 throughout:
  - clean victim: WORDS+1 cycles from request to dhit;
  - dirty victim: 2·WORDS+1 cycles.
  - Each memory stall cycle adds 1.
- dREN and dWEN are never high together. daddr and dstore hold stable while dwait=1.
- dhit=0 in every state except IDLE.
- Reset mid-transaction: all outputs return to their reset values immediately (asynchronous). All frames are invalidated and the memory request is dropped.

## Test plan
Defaults WAYS=4, SETS=8, WORDS=2; memory dwait=0 unless stated.
- Cold read of 0x100 (idx 0, tag 4) → dREN with daddr 0x100 then 0x104; dhit on cycle 3; repeat read hits in the same cycle; hit_count=2, miss_count=1.
- Reads of 0x000, 0x040, 0x080, 0x0C0, 0x100 → fills ways 0–3, then 0x100 evicts way 0 (0x000). A re-read of 0x040 hits; a re-read of 0x000 misses.
- Write 0xDEADBEEF to 0x000, then read 0x040, 0x080, 0x0C0, 0x100 → final miss issues dWEN at 0x000 (0xDEADBEEF) and 0x004, then dREN at 0x100 and 0x104.
- Dirty frames at 0x008 and 0x1F8, then halt → exactly 4 dWEN transfers (0x008, 0x00C, 0x1F8, 0x1FC); flushed=1 and held; later requests give dhit=0.
- dwait=1 for 3 cycles on each word of a fill → daddr held stable; dhit arrives 6 cycles later than the no-stall case.
- nRST asserted during FETCH word 1 → dREN=0 at once; a subsequent read of the same address misses again.
